tx_mailbox_scheduler: RTL and testbench
=======================================

TX_MAILBOX_SCHEDULER -- requirements
Module: tx_mailbox_scheduler

Interface
REQ-001 SHALL have ports: samplePoint input 1, the bit-time clock; all logic on its rising edge.
REQ-002 SHALL have reset input 1, asynchronous, active-high.
REQ-003 SHALL have txReq input 4, a one-cycle request pulse per mailbox.
REQ-004 SHALL have txIdFlat input 116, mailbox i ID at [29i+28:29i]; base ID in bits [10:0].
REQ-005 SHALL have txIde input 4, per-mailbox extended-ID flag.
REQ-006 SHALL have busIdle input 1, meaning interframe space allows a start-of-frame this cycle.
REQ-007 SHALL have txDone input 1 (frame acknowledged), arbLost input 1, and isError input 1.
REQ-008 SHALL have txStart output 1, a one-cycle pulse to the frame transmitter.
REQ-009 SHALL have txSel output 2 (mailbox in flight), txIdOut output 29 and txIdeOut output 1, all latched at txStart.
REQ-010 SHALL have txAck output 4 and txFail output 4, one-cycle per-mailbox completion pulses.
REQ-011 SHALL have pending output 4, txBusy output 1, and errCount output 8.

Function
REQ-012 SHALL set pending[i] on txReq[i]; txReq[i] while pending[i] is already set has no effect.
REQ-013 SHALL form the priority key per mailbox:
- base frame: {id[10:0], 1'b0, 18'b0}
- extended frame: {id[28:18], 1'b1, id[17:0]}
REQ-014 SHALL select, among pending mailboxes, the lowest key; ties go to the lowest index.
REQ-015 SHALL implement state IDLE: if any pending bit is set, go to ARMED next cycle.
REQ-016 SHALL implement state ARMED:
- re-evaluate the selection every cycle, so a higher-priority request pre-empts before start;
- when busIdle=1, pulse txStart, latch txSel/txIdOut/txIdeOut, and go to SEND.
REQ-017 SHALL return ARMED to IDLE if pending becomes all-zero.
REQ-018 SHALL handle results in state SEND, in this order of precedence:
- isError: errCount +1, saturating at 255.
- arbLost: no counter change.
- txDone: clear pending[txSel], pulse txAck[txSel], return to IDLE.
REQ-019 SHALL, after isError or arbLost in SEND, keep pending[txSel] set and return to IDLE; the request retries automatically.
REQ-020 SHALL let set win when txReq[i] coincides with clearing of pending[i]; pending[i] stays 1.
REQ-021 SHALL drive txBusy=1 exactly while state is SEND.
REQ-022 SHALL decrement errCount by 1 on each txDone, flooring at 0.
REQ-023 SHALL ignore txDone, arbLost and isError outside SEND.
REQ-024 SHALL require IDs to be held stable by the host while the mailbox is pending; the values latched at txStart are what is used.

Reset
REQ-025 SHALL, on reset assertion, immediately force:
- state IDLE;
- pending, txAck, txFail, txStart, txSel, txIdOut, txIdeOut, txBusy and errCount all to 0.
REQ-026 SHALL, on reset during SEND, abandon the frame with no txAck or txFail pulse.

Configuration
REQ-027 SHALL, with ONE_SHOT_EN defined, treat isError or arbLost in SEND as final:
- clear pending[txSel];
- pulse txFail[txSel];
- do not retry.
REQ-028 SHALL, without ONE_SHOT_EN, tie txFail to 0 and retry as in REQ-019.

Structure
REQ-029 SHALL place the following in shared package can_pkg:
- mailbox count (4) and ID width (29);
- key width (30);
- the state enumeration IDLE/ARMED/SEND.
REQ-030 SHALL implement key formation and lowest-key selection in sub-module tx_priority_select, which is combinational: pending, IDs and IDE in; index and valid out.

Verification
REQ-031 SHALL cover: txReq=0001 with mailbox 0 base ID 0x123, busIdle=1 -> txStart one cycle after ARMED, txIdOut=0x123; txDone -> txAck=0001, pending=0000.
REQ-032 SHALL cover: mailbox 1 base 0x100, mailbox 2 extended with ID[28:18]=0x100 -> mailbox 1 sent first, then mailbox 2.
REQ-033 SHALL cover: mailbox 3 ID 0x7FF in ARMED with busIdle=0, then mailbox 0 ID 0x001 requested -> txStart selects txSel=0.
REQ-034 SHALL cover: arbLost in SEND -> IDLE, pending unchanged, restart on next busIdle; with ONE_SHOT_EN -> txFail pulse, pending bit cleared.
REQ-035 SHALL cover: 256 consecutive isError -> errCount=255 and saturates; one txDone then gives 254.
REQ-036 SHALL cover: reset asserted mid-SEND -> all outputs 0 asynchronously, no txAck pulse.

Source files
------------

// File: rtl/can_pkg.sv
// can_pkg: shared mailbox/ID sizes, scheduler states and the priority-key helper.
// Optional one-shot (no retry) mode is selected by ONE_SHOT_EN in the top.
package can_pkg;
    localparam int MB_N  = 4;
    localparam int ID_W  = 29;
    localparam int KEY_W = 30;
    localparam int SEL_W = 2;

    typedef enum logic [1:0] {IDLE, ARMED, SEND} state_t;

    // Lower key wins arbitration; base frames beat extended frames with equal base ID.
    function automatic logic [KEY_W-1:0] prio_key(input logic [ID_W-1:0] id, input logic ide);
        return ide ? {id[28:18], 1'b1, id[17:0]} : {id[10:0], 19'b0};
    endfunction
endpackage

// File: rtl/tx_priority_select.sv
// tx_priority_select: combinational lowest-key pick among pending mailboxes, ties to lowest index.
module tx_priority_select
    import can_pkg::*;
(
    input  logic [MB_N-1:0]      pending_i,
    input  logic [MB_N*ID_W-1:0] id_flat_i,
    input  logic [MB_N-1:0]      ide_i,
    output logic [SEL_W-1:0]     sel_o,
    output logic                 valid_o
);
    logic [KEY_W-1:0] key;
    logic [KEY_W-1:0] best;

    always_comb begin
        sel_o   = '0;
        valid_o = 1'b0;
        best    = '1;
        key     = '0;
        for (int i = 0; i < MB_N; i++) begin
            key = prio_key(id_flat_i[i*ID_W +: ID_W], ide_i[i]);
            if (pending_i[i] && (!valid_o || key < best)) begin
                sel_o   = SEL_W'(i);
                best    = key;
                valid_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/tx_mailbox_scheduler.sv
// tx_mailbox_scheduler: arbitrates 4 TX mailboxes onto one frame transmitter with retry and error count.
// Define ONE_SHOT_EN to make arbitration loss / errors final (txFail pulse, no retry).
module tx_mailbox_scheduler
    import can_pkg::*;
(
    input  logic                 samplePoint,
    input  logic                 reset,
    input  logic [MB_N-1:0]      txReq,
    input  logic [MB_N*ID_W-1:0] txIdFlat,
    input  logic [MB_N-1:0]      txIde,
    input  logic                 busIdle,
    input  logic                 txDone,
    input  logic                 arbLost,
    input  logic                 isError,
    output logic                 txStart,
    output logic [SEL_W-1:0]     txSel,
    output logic [ID_W-1:0]      txIdOut,
    output logic                 txIdeOut,
    output logic [MB_N-1:0]      txAck,
    output logic [MB_N-1:0]      txFail,
    output logic [MB_N-1:0]      pending,
    output logic                 txBusy,
    output logic [7:0]           errCount
);
    state_t           state_q;
    logic [MB_N-1:0]  pending_q, pending_d, ack_q, fail_q, sel_mask;
    logic [SEL_W-1:0] sel_q, pick;
    logic [ID_W-1:0]  id_q;
    logic             ide_q, start_q, pick_valid, in_send, clr;
    logic [7:0]       err_q, err_d;

    tx_priority_select u_sel (
        .pending_i (pending_q),
        .id_flat_i (txIdFlat),
        .ide_i     (txIde),
        .sel_o     (pick),
        .valid_o   (pick_valid)
    );

    always_comb begin
        in_send  = state_q == SEND;
        sel_mask = MB_N'(1) << sel_q;
`ifdef ONE_SHOT_EN
        clr = in_send && (isError || arbLost || txDone);
`else
        clr = in_send && !isError && !arbLost && txDone;
`endif
        // A new request in the same cycle as a clear keeps the mailbox pending.
        pending_d = (pending_q & ~(clr ? sel_mask : '0)) | txReq;
        err_d = !in_send ? err_q :
                isError ? (err_q == 8'hFF ? err_q : err_q + 8'd1) :
                (!arbLost && txDone && err_q != 8'd0) ? err_q - 8'd1 : err_q;
    end

    always_ff @(posedge samplePoint or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pending_q <= '0;
            err_q     <= '0;
            start_q   <= 1'b0;
            ack_q     <= '0;
            fail_q    <= '0;
            sel_q     <= '0;
            id_q      <= '0;
            ide_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
            start_q   <= 1'b0;
            ack_q     <= '0;
            fail_q    <= '0;
            case (state_q)
                IDLE: if (|pending_q) state_q <= ARMED;
                ARMED: begin
                    if (!pick_valid) begin
                        state_q <= IDLE;
                    end else if (busIdle) begin
                        state_q <= SEND;
                        start_q <= 1'b1;
                        sel_q   <= pick;
                        id_q    <= txIdFlat[pick*ID_W +: ID_W];
                        ide_q   <= txIde[pick];
                    end
                end
                SEND: begin
                    if (isError || arbLost) begin
                        state_q <= IDLE;
`ifdef ONE_SHOT_EN
                        fail_q  <= sel_mask;
`endif
                    end else if (txDone) begin
                        state_q <= IDLE;
                        ack_q   <= sel_mask;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign txStart  = start_q;
    assign txSel    = sel_q;
    assign txIdOut  = id_q;
    assign txIdeOut = ide_q;
    assign txAck    = ack_q;
    assign txFail   = fail_q;
    assign pending  = pending_q;
    assign txBusy   = in_send;
    assign errCount = err_q;
endmodule

// File: tb/tb_tx_mailbox_scheduler.sv
// tb_tx_mailbox_scheduler: directed + random stimulus checked every cycle against a behavioural model.
// Expectations follow ONE_SHOT_EN when it is defined for the build.
module tb_tx_mailbox_scheduler;
    logic         samplePoint = 1'b0;
    logic         reset;
    logic [3:0]   txReq = '0, txIde = '0, txAck, txFail, pending;
    logic [28:0]  ids [4];
    logic [115:0] txIdFlat;
    logic         busIdle = 0, txDone = 0, arbLost = 0, isError = 0;
    logic         txStart, txIdeOut, txBusy;
    logic [1:0]   txSel;
    logic [28:0]  txIdOut;
    logic [7:0]   errCount;

    int n_cmp = 0, n_bad = 0;

    // model state: phase 0 waiting, 1 armed, 2 frame in flight
    logic [3:0]  m_pend, m_ack, m_fail;
    int          m_ph, m_err, m_sel;
    logic [28:0] m_id;
    logic        m_ide, m_start;

`ifdef ONE_SHOT_EN
    localparam bit ONE_SHOT = 1'b1;
`else
    localparam bit ONE_SHOT = 1'b0;
`endif

    assign txIdFlat = {ids[3], ids[2], ids[1], ids[0]};

    tx_mailbox_scheduler dut (
        .samplePoint(samplePoint), .reset(reset), .txReq(txReq), .txIdFlat(txIdFlat),
        .txIde(txIde), .busIdle(busIdle), .txDone(txDone), .arbLost(arbLost),
        .isError(isError), .txStart(txStart), .txSel(txSel), .txIdOut(txIdOut),
        .txIdeOut(txIdeOut), .txAck(txAck), .txFail(txFail), .pending(pending),
        .txBusy(txBusy), .errCount(errCount)
    );

    always #5 samplePoint = ~samplePoint;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint key_of(input int i);
        longint id = longint'(ids[i]);
        if (txIde[i]) return (id / 262144) * 524288 + 262144 + (id % 262144);
        return (id % 2048) * 524288;
    endfunction

    function automatic int best_of(input logic [3:0] p);
        int bi = -1;
        longint bk = 0;
        for (int i = 0; i < 4; i++)
            if (p[i] && (bi < 0 || key_of(i) < bk)) begin
                bi = i;
                bk = key_of(i);
            end
        return bi;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_ack = 0; m_fail = 0; m_ph = 0; m_err = 0; m_sel = 0;
        m_id = 0; m_ide = 0; m_start = 0;
    endtask

    task automatic model_step(input logic [3:0] req, input logic bi, dn, al, er);
        logic [3:0] clr = 0;
        int b;
        m_start = 0; m_ack = 0; m_fail = 0;
        if (m_ph == 0) begin
            if (m_pend != 0) m_ph = 1;
        end else if (m_ph == 1) begin
            b = best_of(m_pend);
            if (b < 0) m_ph = 0;
            else if (bi) begin
                m_start = 1; m_sel = b; m_id = ids[b]; m_ide = txIde[b]; m_ph = 2;
            end
        end else begin
            if (er || al) begin
                if (er && m_err < 255) m_err++;
                if (ONE_SHOT) begin
                    clr[m_sel] = 1'b1;
                    m_fail[m_sel] = 1'b1;
                end
                m_ph = 0;
            end else if (dn) begin
                clr[m_sel] = 1'b1;
                m_ack[m_sel] = 1'b1;
                if (m_err > 0) m_err--;
                m_ph = 0;
            end
        end
        m_pend = (m_pend & ~clr) | req;
    endtask

    task automatic check_all();
        chk("txStart", 32'(txStart), 32'(m_start));
        chk("txSel", 32'(txSel), 32'(m_sel));
        chk("txIdOut", 32'(txIdOut), 32'(m_id));
        chk("txIdeOut", 32'(txIdeOut), 32'(m_ide));
        chk("txAck", 32'(txAck), 32'(m_ack));
        chk("txFail", 32'(txFail), 32'(m_fail));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("txBusy", 32'(txBusy), 32'(m_ph == 2));
        chk("errCount", 32'(errCount), 32'(m_err));
    endtask

    task automatic tick(input logic [3:0] req, input logic bi, dn, al, er);
        txReq = req; busIdle = bi; txDone = dn; arbLost = al; isError = er;
        @(posedge samplePoint);
        model_step(req, bi, dn, al, er);
        #1;
        check_all();
    endtask

    task automatic wait_start(input string tag);
        for (int k = 0; k < 10 && !txStart; k++) tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk(tag, 32'(txStart), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && (m_pend != 0 || m_ph != 0); k++)
            tick(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("drained", 32'(pending), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) ids[i] = '0;
        reset = 1'b1;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;

        // single base frame from mailbox 0
        ids[0] = 29'h123;
        tick(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("d1_start", 32'(txStart), 32'd1);
        chk("d1_id", 32'(txIdOut), 32'h123);
        tick(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("d1_ack", 32'(txAck), 32'b0001);
        chk("d1_pend", 32'(pending), 32'b0000);

        // base beats extended with equal base ID
        ids[1] = 29'h100;
        ids[2] = (29'h100 << 18) | 29'h00055;
        txIde = 4'b0100;
        tick(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_start("d2_start1");
        chk("d2_sel1", 32'(txSel), 32'd1);
        tick(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_start("d2_start2");
        chk("d2_sel2", 32'(txSel), 32'd2);
        chk("d2_ide", 32'(txIdeOut), 32'd1);
        drain();

        // late higher-priority request pre-empts an armed one
        txIde = 4'b0000;
        ids[3] = 29'h7FF;
        tick(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        ids[0] = 29'h001;
        tick(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("d3_start", 32'(txStart), 32'd1);
        chk("d3_sel", 32'(txSel), 32'd0);
        drain();

        // arbitration loss: retry, or fail in one-shot mode
        tick(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_start("d4_start");
        tick(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("d4_pend", 32'(pending), ONE_SHOT ? 32'b0000 : 32'b0010);
        chk("d4_fail", 32'(txFail), ONE_SHOT ? 32'b0010 : 32'b0000);
        if (!ONE_SHOT) wait_start("d4_restart");
        drain();

        // error counter saturation then one txDone decrement
        for (int k = 0; k < 1200 && m_err < 255; k++) tick(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) tick(4'b0001, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("d5_sat", 32'(errCount), 32'd255);
        for (int k = 0; k < 10 && m_ack == 0; k++) tick(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("d5_dec", 32'(errCount), 32'd254);
        drain();

        // asynchronous reset in the middle of a frame
        tick(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_start("d6_start");
        chk("d6_busy", 32'(txBusy), 32'd1);
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all();
        txDone = 1'b1;
        @(posedge samplePoint);
        #1;
        chk("d6_noack", 32'(txAck), 32'd0);
        check_all();
        reset = 1'b0;

        // randomized traffic; IDs only change while their mailbox is idle
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++)
                if (!m_pend[i] && !(m_ph == 2 && m_sel == i) && ($urandom % 4 == 0)) begin
                    ids[i] = 29'($urandom);
                    txIde[i] = 1'($urandom);
                end
            tick(4'($urandom) & 4'($urandom), 1'($urandom), ($urandom % 3) == 0,
                 ($urandom % 6) == 0, ($urandom % 8) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
